// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: IMEM address/data, hazard/branch inputs from ID and the IF/ID register outputs.
interface if_fetch_stage_if;
  logic        if_stop;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;

  modport master (
    input  if_stop, id_branch_taken, id_branch_target, imem_rdata,
    output imem_addr, if_inst, id_inst, id_pc, id_pc4, id_valid
  );

  modport slave (
    output if_stop, id_branch_taken, id_branch_target, imem_rdata,
    input  imem_addr, if_inst, id_inst, id_pc, id_pc4, id_valid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register, load-use stall and delay-slot redirect.
// Optional stall/redirect counters are built when IF_STALL_CNT_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_fetch_stage_if.master     bus
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          redirect_cnt
`endif
);

  localparam logic [0:0] RUN        = 1'b0;
  localparam logic [0:0] HOLD_REDIR = 1'b1;

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] pc_plus4;
  logic [0:0]  state;

  assign pc_plus4 = pc_q + 32'd4;
  assign state    = pend_valid_q ? HOLD_REDIR : RUN;

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;
    id_valid_d    = id_valid_q;
    if (bus.if_stop) begin
      // PC and id_pc/id_pc4 hold; a branch resolved now is remembered until the stall clears
      id_inst_d  = '0;
      id_valid_d = 1'b0;
      if (bus.id_branch_taken) begin
        pend_valid_d  = 1'b1;
        pend_target_d = bus.id_branch_target;
      end
    end else begin
      id_inst_d  = bus.imem_rdata;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_plus4;
      id_valid_d = 1'b1;
      if (bus.id_branch_taken) begin
        pc_d         = bus.id_branch_target;
        pend_valid_d = 1'b0;
      end else if (state == HOLD_REDIR) begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      id_inst_q     <= '0;
      id_pc_q       <= '0;
      id_pc4_q      <= '0;
      id_valid_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
      id_valid_q    <= id_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_inst   = bus.imem_rdata;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc4_q;
  assign bus.id_valid  = id_valid_q;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;
  logic        redirect;

  // Cases 2 and 3 of next-PC selection: unstalled with a live or owed redirect
  assign redirect = !bus.if_stop && (bus.id_branch_taken || pend_valid_q);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (bus.if_stop && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (redirect && (redir_cnt_q != '1))    redir_cnt_d = redir_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign redirect_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized stall/branch traffic.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk;
  logic rst_n;
  if_fetch_stage_if bus();

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cycles, redirect_cnt;
  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt));
`else
  if_fetch_stage #(.RESET_PC(RST_PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // Memory image: word at byte address a is its word index a>>2
  assign bus.imem_rdata = bus.imem_addr >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model state
  logic [31:0] m_pc, m_inst, m_idpc, m_idpc4, m_ptgt, m_stall, m_redir;
  logic        m_valid, m_pend;

  task automatic model_reset();
    m_pc = RST_PC; m_inst = '0; m_idpc = '0; m_idpc4 = '0; m_valid = 1'b0;
    m_pend = 1'b0; m_ptgt = '0; m_stall = '0; m_redir = '0;
  endtask

  // Apply one clock with the given inputs and advance the model by the fetch rules
  task automatic cycle(input logic stop, input logic taken, input logic [31:0] tgt);
    bus.if_stop = stop; bus.id_branch_taken = taken; bus.id_branch_target = tgt;
    @(posedge clk);
    if (stop) begin
      m_inst = 0; m_valid = 0;
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (taken) begin m_pend = 1; m_ptgt = tgt; end
    end else begin
      m_inst = m_pc >> 2; m_idpc = m_pc; m_idpc4 = m_pc + 4; m_valid = 1;
      if (taken || m_pend) begin
        m_pc = taken ? tgt : m_ptgt;
        m_pend = 0;
        if (m_redir != 32'hFFFF_FFFF) m_redir = m_redir + 1;
      end else begin
        m_pc = m_pc + 4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_stop = 0; bus.id_branch_taken = 0; bus.id_branch_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.imem_addr !== RST_PC || bus.id_inst !== 0 || bus.id_pc !== 0 ||
        bus.id_pc4 !== 0 || bus.id_valid !== 0) begin
      n_err++;
      $display("FAIL reset_outputs: addr=%h inst=%h pc=%h pc4=%h v=%b, required addr=%h rest 0",
               bus.imem_addr, bus.id_inst, bus.id_pc, bus.id_pc4, bus.id_valid, RST_PC);
    end
`ifdef IF_STALL_CNT_EN
    n_vec++;
    if (stall_cycles !== 0 || redirect_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_counters: stall=%0d redir=%0d, required 0 0", stall_cycles, redirect_cnt);
    end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, '0);
      n_vec++;
      if (bus.id_pc !== RST_PC + 32'(4*i) || bus.id_inst !== (RST_PC >> 2) + 32'(i) ||
          bus.id_valid !== 1'b1) begin
        n_err++;
        $display("FAIL seq_fetch%0d: id_pc=%h inst=%h v=%b, required id_pc=%h inst=%h v=1",
                 i, bus.id_pc, bus.id_inst, bus.id_valid, RST_PC + 32'(4*i), (RST_PC >> 2) + 32'(i));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, '0);
      n_vec++;
      if (bus.id_inst !== 0 || bus.id_valid !== 0 || bus.imem_addr !== 32'h0040_0008) begin
        n_err++;
        $display("FAIL stall_bubble%0d: inst=%h v=%b addr=%h, required 0 0 00400008",
                 i, bus.id_inst, bus.id_valid, bus.imem_addr);
      end
    end
    cycle(0, 0, '0);
    n_vec++;
    if (bus.id_pc !== 32'h0040_0008 || bus.id_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: id_pc=%h v=%b, required 00400008 1", bus.id_pc, bus.id_valid);
    end
`ifdef IF_STALL_CNT_EN
    n_vec++;
    if (stall_cycles !== 32'd2) begin
      n_err++;
      $display("FAIL stall_count: got %0d, required 2", stall_cycles);
    end
`endif
  endtask

  task automatic test_branch();
    cycle(0, 0, '0);
    cycle(0, 1, 32'h0040_0100);
    n_vec++;
    if (bus.id_pc !== 32'h0040_0010 || bus.imem_addr !== 32'h0040_0100) begin
      n_err++;
      $display("FAIL branch_delay_slot: id_pc=%h addr=%h, required 00400010 00400100",
               bus.id_pc, bus.imem_addr);
    end
`ifdef IF_STALL_CNT_EN
    n_vec++;
    if (redirect_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL branch_count: got %0d, required 1", redirect_cnt);
    end
`endif
  endtask

  task automatic test_branch_during_stall();
    cycle(1, 1, 32'h0040_0200);
    n_vec++;
    if (bus.imem_addr !== 32'h0040_0100 || dut.pend_valid_q !== 1'b1 || bus.id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pend_latch: addr=%h pend=%b v=%b, required 00400100 1 0",
               bus.imem_addr, dut.pend_valid_q, bus.id_valid);
    end
    cycle(0, 0, '0);
    n_vec++;
    if (bus.imem_addr !== 32'h0040_0200 || bus.id_pc !== 32'h0040_0100 || dut.pend_valid_q !== 1'b0) begin
      n_err++;
      $display("FAIL pend_apply: addr=%h id_pc=%h pend=%b, required 00400200 00400100 0",
               bus.imem_addr, bus.id_pc, dut.pend_valid_q);
    end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, '0);
    n_vec++;
    if (bus.imem_addr !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0) begin
      n_err++;
      $display("FAIL pc_wrap: addr=%h id_pc=%h id_pc4=%h, required 00000000 fffffffc 00000000",
               bus.imem_addr, bus.id_pc, bus.id_pc4);
    end
  endtask

  task automatic test_reset_mid_hold();
    cycle(1, 1, 32'h1234_0000);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (dut.pend_valid_q !== 1'b0 || bus.imem_addr !== RST_PC || bus.id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: pend=%b addr=%h v=%b, required 0 %h 0",
               dut.pend_valid_q, bus.imem_addr, bus.id_valid, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, '0);
    n_vec++;
    if (bus.id_pc !== RST_PC || bus.imem_addr !== RST_PC + 32'd4) begin
      n_err++;
      $display("FAIL reset_hold_resume: id_pc=%h addr=%h, required %h %h",
               bus.id_pc, bus.imem_addr, RST_PC, RST_PC + 32'd4);
    end
  endtask

  task automatic test_random();
    logic stop, taken;
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      stop  = ($urandom_range(0, 99) < 30);
      taken = ($urandom_range(0, 99) < 20);
      tgt   = $urandom;
      if (stop && taken && m_pend) taken = 1'b0;
      n_vec++;
      if (stop && taken && m_pend) begin
        n_err++;
        $display("FAIL illegal_double_branch: cycle %0d, branch while redirect already owed", i);
      end
      cycle(stop, taken, tgt);
      n_vec++;
      if (bus.imem_addr !== m_pc || bus.if_inst !== (m_pc >> 2) || bus.id_inst !== m_inst ||
          bus.id_pc !== m_idpc || bus.id_pc4 !== m_idpc4 || bus.id_valid !== m_valid) begin
        n_err++;
        $display("FAIL random%0d: addr=%h if=%h inst=%h pc=%h pc4=%h v=%b, required %h %h %h %h %h %b",
                 i, bus.imem_addr, bus.if_inst, bus.id_inst, bus.id_pc, bus.id_pc4, bus.id_valid,
                 m_pc, m_pc >> 2, m_inst, m_idpc, m_idpc4, m_valid);
      end
`ifdef IF_STALL_CNT_EN
      n_vec++;
      if (stall_cycles !== m_stall || redirect_cnt !== m_redir) begin
        n_err++;
        $display("FAIL random_cnt%0d: stall=%0d redir=%0d, required %0d %0d",
                 i, stall_cycles, redirect_cnt, m_stall, m_redir);
      end
`endif
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_stall();
    test_branch();
    test_branch_during_stall();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
